power_mode_ctrl: RTL and testbench
==================================

// Module: power_mode_ctrl
// PURPOSE
//  Power-mode sequencer: watches system activity and explicit sleep/wake
//  requests, decides NORMAL / LP / SHUTDOWN and drives the registered
//  powermode_t p that feeds the clock gater directly downstream.
//  Idle-time escalation, forced sleep and a timed wake ramp (via LP) from SHUTDOWN.
// PARAMETERS
//  CNT_W     8   width of idle/wake/dwell counters
//  LP_IDLE   16  consecutive idle cycles in NORMAL before entering LP (>=1)
//  SD_IDLE   64  consecutive idle cycles in LP before entering SHUTDOWN (>=1)
//  WAKE_CYC  4   cycles spent in WAKE (p=LP) leaving SHUTDOWN (>=1)
//  DWELL     8   min cycles in a mode before a down-transition (PMC_HYST_EN only)
// PORTS
//  clk        in   1            system clock (ungated)
//  rst        in   1            asynchronous, active-low reset
//  activity   in   1            1 = block busy this cycle (not idle)
//  wake_req   in   1            explicit wake request, level
//  sleep_req  in   1            forced SHUTDOWN request, level
//  p          out  powermode_t  registered mode to clock gater
//  mode_chg   out  1            1-cycle pulse the cycle after p changes value
//  in_wake    out  1            1 while in WAKE state
// BEHAVIOUR
//  Reset (rst=0, async): state=NORM, p=NORMAL, mode_chg=0, in_wake=0, all counters 0.
//  States / p: NORM->NORMAL, LPS->LP, SD->SHUTDOWN, WAKE->LP.
//  idle_cnt: +1 per cycle with activity=0, saturates at 2^CNT_W-1; cleared on
//   activity=1 and on every state transition.
//  NORM: activity=0 & sleep_req=1 -> SD; idle_cnt==LP_IDLE-1 & activity=0 -> LPS.
//  LPS : activity|wake_req -> NORM (next cycle); sleep_req -> SD;
//        idle_cnt==SD_IDLE-1 & activity=0 -> SD.
//  SD  : activity|wake_req -> WAKE, wake_cnt=0; else hold (sleep_req ignored).
//  WAKE: wake_cnt +1/cycle; wake_cnt==WAKE_CYC-1 -> NORM. activity, wake_req,
//        sleep_req ignored in WAKE (ramp always completes).
//  Priority per cycle: activity/wake_req > sleep_req > idle timeout.
//  p, in_wake registered from next-state: change visible 1 cycle after deciding
//   edge. mode_chg=1 exactly the cycle after p changes; WAKE->NORM pulses
//   (LP->NORMAL), SD->WAKE pulses (SHUTDOWN->LP).
//  Latency: LPS->NORM on activity = 1 cycle; SD->NORMAL = 1+WAKE_CYC cycles.
//  Counters compare with ==; CNT_W must hold max(LP_IDLE,SD_IDLE,WAKE_CYC,DWELL).
//  Reset mid-WAKE or mid-count: immediate return to reset values, no pulse.
//  SHUTDOWN holds p stable; block runs on ungated clk so wake always works.
// CONFIGURATION
//  PMC_HYST_EN defined: dwell_cnt cleared on each transition, +1/cycle,
//   saturating; down-transitions (NORM->LPS, NORM->SD, LPS->SD, incl. forced
//   sleep_req) blocked until dwell_cnt>=DWELL-1; request/timeout held pending,
//   taken when dwell satisfied if still valid. Up-transitions never blocked.
//  PMC_HYST_EN undefined: no dwell logic, DWELL unused, transitions as above.
// TESTING
//  Reset: rst=0 mid-run -> p=NORMAL, mode_chg=0, in_wake=0 asynchronously.
//  Idle: activity=0 from reset -> p=LP after 16 cycles, SHUTDOWN 64 cycles later,
//   mode_chg one pulse at each.
//  Wake: in SD, wake_req 1 cycle -> p=LP, in_wake=1 for 4 cycles, then p=NORMAL.
//  Priority: in LPS, activity=1 & sleep_req=1 same cycle -> p=NORMAL, not SHUTDOWN.
//  Forced: in NORM, sleep_req=1, activity=0 -> p=SHUTDOWN next cycle; idle_cnt=0.
//  Hyst (PMC_HYST_EN, DWELL=8): sleep_req 2 cycles after entering NORM, held ->
//   SHUTDOWN only after 8 cycles in NORM; without macro -> next cycle.

Source files
------------

// File: rtl/power_mode_ctrl.sv
// power_mode_ctrl: power-mode sequencer (NORMAL/LP/SHUTDOWN) with idle escalation, forced sleep and timed wake ramp; optional dwell hysteresis under PMC_HYST_EN
package power_mode_pkg;
  typedef enum logic [1:0] {NORMAL = 2'd0, LP = 2'd1, SHUTDOWN = 2'd2} powermode_t;
endpackage

module power_mode_ctrl
  import power_mode_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LP_IDLE  = 16,
  parameter int SD_IDLE  = 64,
  parameter int WAKE_CYC = 4,
  parameter int DWELL    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activity,
  input  logic       wake_req,
  input  logic       sleep_req,
  output powermode_t p,
  output logic       mode_chg,
  output logic       in_wake
);
  typedef enum logic [1:0] {NORM, LPS, SD, WAKE} state_t;
  localparam logic [CNT_W-1:0] LP_LIM   = CNT_W'(LP_IDLE - 1);
  localparam logic [CNT_W-1:0] SD_LIM   = CNT_W'(SD_IDLE - 1);
  localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYC - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] idle_q, idle_d, wake_q, wake_d;
  powermode_t       p_d;
  logic             wake_up, to_hit, to_req, down_ok, chg;
`ifdef PMC_HYST_EN
  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL - 1);
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             pend_q, pend_d;
  // Down-transitions wait for the dwell time; a timeout seen while blocked stays pending
  always_comb begin
    down_ok = dwell_q >= DWELL_LIM;
    to_req  = !activity && (to_hit || pend_q);
    dwell_d = chg ? '0 : (&dwell_q ? dwell_q : dwell_q + 1'b1);
    pend_d  = (chg || activity) ? 1'b0 : (pend_q || to_hit);
  end
  // Dwell and pending-timeout registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dwell_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      pend_q  <= pend_d;
    end
`else
  logic unused_dwell;
  assign unused_dwell = DWELL > 0;
  assign down_ok      = 1'b1;
  assign to_req       = !activity && to_hit;
`endif
  // Next-state decision: wake-up beats forced sleep, which beats idle timeout
  always_comb begin
    wake_up = activity || wake_req;
    to_hit  = !activity && idle_q == (state_q == NORM ? LP_LIM : SD_LIM);
    state_d = state_q;
    case (state_q)
      NORM: if (!wake_up && down_ok && (sleep_req || to_req)) state_d = sleep_req ? SD : LPS;
      LPS:  if (wake_up) state_d = NORM;
            else if (down_ok && (sleep_req || to_req)) state_d = SD;
      SD:   if (wake_up) state_d = WAKE;
      WAKE: if (wake_q == WAKE_LIM) state_d = NORM;
      default: state_d = NORM;
    endcase
    chg    = state_d != state_q;
    idle_d = (chg || activity) ? '0 : (&idle_q ? idle_q : idle_q + 1'b1);
    wake_d = (state_q == WAKE && !chg) ? wake_q + 1'b1 : '0;
    p_d    = state_d == NORM ? NORMAL : (state_d == SD ? SHUTDOWN : LP);
  end
  // State, counters and outputs, all registered from next-state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= NORM;
      idle_q   <= '0;
      wake_q   <= '0;
      p        <= NORMAL;
      mode_chg <= 1'b0;
      in_wake  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wake_q   <= wake_d;
      p        <= p_d;
      mode_chg <= p_d != p;
      in_wake  <= state_d == WAKE;
    end
endmodule

// File: tb/tb_power_mode_ctrl.sv
// tb_power_mode_ctrl: directed table, corner sequences and randomized model comparison for power_mode_ctrl
module tb_power_mode_ctrl;
  import power_mode_pkg::*;
  localparam int LP_IDLE = 16, SD_IDLE = 64, WAKE_CYC = 4;
  logic clk = 0, rst = 0, activity = 0, wake_req = 0, sleep_req = 0;
  powermode_t p;
  logic mode_chg, in_wake;
  int checks = 0, failures = 0;
  typedef struct {logic a, w, s; int n; logic [1:0] ep; logic ec, ew;} vec_t;
  vec_t tbl[$];
  int m_mode, m_idle, m_wleft;
  logic [1:0] m_p, m_prev;
  logic m_chg, m_wake;

  always #5 clk = ~clk;

  power_mode_ctrl #(.CNT_W(8), .LP_IDLE(LP_IDLE), .SD_IDLE(SD_IDLE), .WAKE_CYC(WAKE_CYC), .DWELL(8)) dut (
    .clk(clk), .rst(rst), .activity(activity), .wake_req(wake_req), .sleep_req(sleep_req),
    .p(p), .mode_chg(mode_chg), .in_wake(in_wake));

  task automatic chk(string nm, logic [1:0] got, logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_wleft = 0; m_p = 2'd0; m_chg = 0; m_wake = 0;
  endtask

  // Modes: 0 normal, 1 low power, 2 shutdown, 3 wake ramp
  task automatic model_step(logic a, logic w, logic s);
    int nxt, seen;
    nxt = m_mode;
    seen = m_idle + 1;
    if (m_mode == 0) begin
      if (!(a || w) && s) nxt = 2;
      else if (!(a || w) && seen == LP_IDLE) nxt = 1;
    end else if (m_mode == 1) begin
      if (a || w) nxt = 0;
      else if (s || seen == SD_IDLE) nxt = 2;
    end else if (m_mode == 2) begin
      if (a || w) begin nxt = 3; m_wleft = WAKE_CYC; end
    end else begin
      m_wleft--;
      if (m_wleft == 0) nxt = 0;
    end
    m_idle = (nxt != m_mode || a) ? 0 : (seen > 255 ? 255 : seen);
    m_mode = nxt;
    m_prev = m_p;
    m_p = nxt == 0 ? 2'd0 : (nxt == 2 ? 2'd2 : 2'd1);
    m_chg = m_p != m_prev;
    m_wake = nxt == 3;
  endtask

  task automatic cyc(logic a, logic w, logic s, bit cmp);
    @(negedge clk);
    activity = a; wake_req = w; sleep_req = s;
    @(posedge clk);
    model_step(a, w, s);
    #1;
    if (cmp) begin
      chk("rand_p", p, m_p);
      chk("rand_mode_chg", {1'b0, mode_chg}, {1'b0, m_chg});
      chk("rand_in_wake", {1'b0, in_wake}, {1'b0, m_wake});
    end
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    #2 rst = 0;
    activity = 0; wake_req = 0; sleep_req = 0;
    #1;
    chk({nm, "_p"}, p, 2'd0);
    chk({nm, "_mode_chg"}, {1'b0, mode_chg}, 2'd0);
    chk({nm, "_in_wake"}, {1'b0, in_wake}, 2'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    #12;
    do_reset("reset_init");
`ifdef PMC_HYST_EN
    repeat (LP_IDLE) cyc(0, 0, 0, 0);
    chk("hyst_lp", p, 2'd1);
    cyc(1, 0, 0, 0);
    chk("hyst_norm", p, 2'd0);
    repeat (2) cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0);
    chk("hyst_blocked", p, 2'd0);
    cyc(0, 0, 1, 0);
    chk("hyst_sd", p, 2'd2);
    chk("hyst_chg", {1'b0, mode_chg}, 2'd1);
`else
    tbl.push_back('{1'b0, 1'b0, 1'b0, LP_IDLE - 1, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, LP_IDLE, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, SD_IDLE - 1, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 3, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1, 2'd1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, WAKE_CYC - 1, 2'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 2'd1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, WAKE_CYC, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, LP_IDLE, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 2, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 2, 2'd0, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].a, tbl[i].w, tbl[i].s, 0);
      chk($sformatf("vec%0d_p", i), p, tbl[i].ep);
      chk($sformatf("vec%0d_mode_chg", i), {1'b0, mode_chg}, {1'b0, tbl[i].ec});
      chk($sformatf("vec%0d_in_wake", i), {1'b0, in_wake}, {1'b0, tbl[i].ew});
    end
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("mid_wake_in_wake", {1'b0, in_wake}, 2'd1);
    do_reset("reset_mid_wake");
    cyc(0, 0, 0, 0);
    chk("post_reset_chg", {1'b0, mode_chg}, 2'd0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset("reset_rand");
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, 1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
